// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: sequential instruction fetch with req/ack memory handshake, credit-limited FIFO and redirect flush
module instr_fetch_buffer #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 9,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_rdata,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    instr_valid,
  output logic [INSTR_W-1:0]      instr_data,
  output logic [ADDR_W-1:0]       instr_pc,
  input  logic                    instr_ready,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [INSTR_W+ADDR_W-1:0] mem_q [DEPTH];
  logic ack_v, push, pop;
  always_comb begin
    ack_v = imem_ack && state_q != IDLE;
    push = ack_v && state_q == FETCH && !redirect_valid;
    pop = count_q != '0 && instr_ready && !redirect_valid;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + PW'(push);
    rd_d = redirect_valid ? '0 : rd_q + PW'(pop);
    fetch_pc_d = redirect_valid ? redirect_pc : push ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    state_d = state_q == IDLE ? (count_q < CW'(DEPTH) ? FETCH : IDLE)
            : !ack_v ? state_q
            : state_q == DROP ? FETCH
            : (count_d < CW'(DEPTH) ? FETCH : IDLE);
    // an unacked request cannot be withdrawn, so a redirect must wait it out in DROP
    if (redirect_valid) state_d = (state_q != IDLE && !imem_ack) ? DROP : FETCH;
    addr_d = state_d == DROP ? addr_q : fetch_pc_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {imem_rdata, addr_q};
  end
  assign imem_req = state_q != IDLE;
  assign imem_addr = addr_q;
  assign instr_valid = count_q != '0;
  assign {instr_data, instr_pc} = instr_valid ? mem_q[rd_q] : '0;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed and randomized checks of instr_fetch_buffer against a queue-based fetch model
module tb_instr_fetch_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic imem_req, imem_ack = 1'b0, redirect_valid = 1'b0, instr_valid, instr_ready = 1'b1;
  logic [7:0] imem_addr, redirect_pc = '0, instr_pc;
  logic [8:0] imem_rdata = '0, instr_data;
  logic [2:0] fifo_count;

  instr_fetch_buffer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [16:0] q[$];
  logic [7:0] exp_pc = '0, hold_addr = '0;
  bit dropping = 0, hold_pend = 0, rnd_ready = 0;
  int wcnt = 0, mode = 0, npush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 ack tied high, 1 ack after 3 wait cycles, 2 random ack, 3 never ack
  task automatic cycle(input bit rv = 1'b0, input logic [7:0] rpc = '0);
    @(negedge clk);
    check("count", 32'(fifo_count), q.size());
    check("valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("head_pc", 32'(instr_pc), 32'(q[0][7:0]));
      check("head_data", 32'(instr_data), 32'(q[0][16:8]));
    end
    if (hold_pend) begin
      check("hold_req", 32'(imem_req), 1);
      check("hold_addr", 32'(imem_addr), 32'(hold_addr));
    end
    if (imem_req && !dropping) begin
      check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
      check("credit", 32'(fifo_count < DEPTH), 1);
    end
    redirect_valid = rv;
    redirect_pc = rpc;
    if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
    imem_ack = mode == 0 ? 1'b1 : mode == 1 ? (imem_req && wcnt == 3)
             : mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
    imem_rdata = 9'($urandom);
    #1;
    hold_pend = imem_req && !imem_ack;
    hold_addr = imem_addr;
    wcnt = (imem_req && !imem_ack) ? wcnt + 1 : 0;
    if (rv) begin
      q.delete();
      exp_pc = rpc;
      dropping = imem_req && !imem_ack;
    end else begin
      if (instr_valid && instr_ready && q.size() != 0) void'(q.pop_front());
      if (imem_req && imem_ack) begin
        if (dropping) dropping = 0;
        else begin
          q.push_back({imem_rdata, imem_addr});
          exp_pc++;
          npush++;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_data", 32'(instr_data), 0);
    check("rst_pc", 32'(instr_pc), 0);
    check("rst_count", 32'(fifo_count), 0);
    q.delete();
    exp_pc = '0;
    dropping = 0;
    hold_pend = 0;
    wcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_req", 32'(imem_req), 1);
    check("first_addr", 32'(imem_addr), 0);
  endtask

  initial begin
    #2;
    do_reset();
    for (int k = 2; k <= 8; k++) begin
      cycle();
      #1;
      check("t1_req", 32'(imem_req), 1);
      check("t1_addr", 32'(imem_addr), k - 1);
      check("t1_pc", 32'(instr_pc), k - 2);
    end
    instr_ready = 1'b0;
    repeat (8) cycle();
    #1;
    check("t2_full", 32'(fifo_count), 4);
    check("t2_req_low", 32'(imem_req), 0);
    instr_ready = 1'b1;
    repeat (12) cycle();
    #1;
    check("t2_resume", 32'(imem_req), 1);
    do_reset();
    mode = 1;
    npush = 0;
    repeat (16) cycle();
    check("t3_rate", npush, 4);
    mode = 0;
    do_reset();
    repeat (5) cycle();
    #1;
    check("t4_at5", 32'(imem_addr), 8'h05);
    mode = 3;
    cycle(1'b1, 8'h40);
    #1;
    check("t4_drop_req", 32'(imem_req), 1);
    check("t4_drop_addr", 32'(imem_addr), 8'h05);
    check("t4_flushed", 32'(fifo_count), 0);
    cycle();
    mode = 0;
    cycle();
    #1;
    check("t4_new_addr", 32'(imem_addr), 8'h40);
    check("t4_empty", 32'(instr_valid), 0);
    cycle();
    #1;
    check("t4_head_pc", 32'(instr_pc), 8'h40);
    cycle(1'b1, 8'hFE);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'hFE + 8'(k);
      #1;
      check("t5_wrap", 32'(imem_addr), 32'(e));
      cycle();
    end
    cycle(1'b1, 8'h80);
    #1;
    check("t6_count", 32'(fifo_count), 0);
    check("t6_valid", 32'(instr_valid), 0);
    check("t6_addr", 32'(imem_addr), 8'h80);
    mode = 3;
    cycle();
    cycle();
    mode = 0;
    @(negedge clk);
    #2;
    do_reset();
    cycle();
    #1;
    check("t6_after_rst", 32'(instr_pc), 0);
    check("t6_after_rst_v", 32'(instr_valid), 1);
    do_reset();
    mode = 2;
    rnd_ready = 1;
    repeat (3000) cycle($urandom_range(0, 19) == 0, 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
